// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one 8-bit ALU between two requesters
//
// Ports:
//   CLK, RESET                   clock (rising edge), asynchronous active-high reset
//   VALIDn, OPn, An, Bn          request pending, ALU opcode, operands for port n (n = 0, 1)
//   GNTn                         one-cycle pulse; operands captured at the edge ending this cycle
//   DONEn                        one-cycle pulse; RESULT_OUT / ZERO_OUT / ERR_OUT valid
//   RESULT_OUT, ZERO_OUT, ERR_OUT captured ALU result, COMP and illegal-opcode flag
//   ALU_DATA1, ALU_DATA2         registered ALU operands
//   ALU_SELECT                   registered ALU opcode
//   ALU_RESULT, ALU_COMP         ALU outputs, sampled WAIT_CYCLES cycles after issue
//   BUSY                         high whenever the arbiter is not idle
//   LOCK0, LOCK1                 only when ALU_ARB_LOCK_EN is defined: hold the ALU for
//                                back-to-back operations, up to LOCK_MAX grants in a row
//
// Optional feature macro: ALU_ARB_LOCK_EN
module alu_arbiter #(
    parameter int WAIT_CYCLES = 1,
    parameter int LOCK_MAX    = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       VALID0,
    input  logic       VALID1,
    input  logic [3:0] OP0,
    input  logic [3:0] OP1,
    input  logic [7:0] A0,
    input  logic [7:0] A1,
    input  logic [7:0] B0,
    input  logic [7:0] B1,
`ifdef ALU_ARB_LOCK_EN
    input  logic       LOCK0,
    input  logic       LOCK1,
`endif
    output logic       GNT0,
    output logic       GNT1,
    output logic       DONE0,
    output logic       DONE1,
    output logic [7:0] RESULT_OUT,
    output logic       ZERO_OUT,
    output logic       ERR_OUT,
    output logic [7:0] ALU_DATA1,
    output logic [7:0] ALU_DATA2,
    output logic [3:0] ALU_SELECT,
    input  logic [7:0] ALU_RESULT,
    input  logic       ALU_COMP,
    output logic       BUSY
);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 7 || LOCK_MAX < 1 || LOCK_MAX > 15) begin : g_param_check
        $error("alu_arbiter: WAIT_CYCLES must be 1..7 and LOCK_MAX 1..15");
    end

    localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic       last_gnt_q, last_gnt_d;
    logic       port_q, port_d;          // port owning the in-flight operation
    logic [2:0] cnt_q, cnt_d;
    logic       illegal_q, illegal_d;    // in-flight opcode had OP[3] set
    logic [7:0] data1_q, data1_d;
    logic [7:0] data2_q, data2_d;
    logic [3:0] select_q, select_d;
    logic [7:0] result_q, result_d;
    logic       zero_q, zero_d;
    logic       err_q, err_d;
    logic       gnt0_q, gnt0_d;
    logic       gnt1_q, gnt1_d;
    logic       done0_q, done0_d;
    logic       done1_q, done1_d;
    logic       busy_q, busy_d;
`ifdef ALU_ARB_LOCK_EN
    logic [3:0] lock_cnt_q, lock_cnt_d;
    logic       lock_ok;
`endif

    logic       issue;
    logic       issue_port;
    logic [3:0] op_sel;

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        port_d     = port_q;
        cnt_d      = cnt_q;
        illegal_d  = illegal_q;
        data1_d    = data1_q;
        data2_d    = data2_q;
        select_d   = select_q;
        result_d   = result_q;
        zero_d     = zero_q;
        err_d      = err_q;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
        issue      = 1'b0;
        issue_port = 1'b0;
`ifdef ALU_ARB_LOCK_EN
        lock_cnt_d = lock_cnt_q;
        lock_ok    = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
`ifdef ALU_ARB_LOCK_EN
                lock_cnt_d = 4'd0;
`endif
                if (VALID0 || VALID1) begin
                    issue = 1'b1;
                    // With both pending, the port that did not win last time goes first.
                    issue_port = (VALID0 && VALID1) ? ~last_gnt_q : VALID1;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    result_d = illegal_q ? 8'h00 : ALU_RESULT;
                    zero_d   = illegal_q ? 1'b1  : ALU_COMP;
                    err_d    = illegal_q;
                    done0_d  = ~port_q;
                    done1_d  = port_q;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
`ifdef ALU_ARB_LOCK_EN
                lock_ok = port_q ? (LOCK1 && VALID1) : (LOCK0 && VALID0);
                if (lock_ok && (lock_cnt_q < 4'(LOCK_MAX))) begin
                    issue      = 1'b1;
                    issue_port = port_q;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        op_sel = issue_port ? OP1 : OP0;

        if (issue) begin
            state_d    = S_ISSUE;
            last_gnt_d = issue_port;
            port_d     = issue_port;
            cnt_d      = WAIT_LOAD;
            data1_d    = issue_port ? A1 : A0;
            data2_d    = issue_port ? B1 : B0;
            // Illegal opcodes still occupy the ALU but drive it with a harmless code.
            illegal_d  = op_sel[3];
            select_d   = op_sel[3] ? 4'b0000 : op_sel;
            gnt0_d     = ~issue_port;
            gnt1_d     = issue_port;
`ifdef ALU_ARB_LOCK_EN
            lock_cnt_d = lock_cnt_d + 4'd1;
`endif
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            last_gnt_q <= 1'b1;
            port_q     <= 1'b0;
            cnt_q      <= 3'd0;
            illegal_q  <= 1'b0;
            data1_q    <= 8'h00;
            data2_q    <= 8'h00;
            select_q   <= 4'h0;
            result_q   <= 8'h00;
            zero_q     <= 1'b0;
            err_q      <= 1'b0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            busy_q     <= 1'b0;
`ifdef ALU_ARB_LOCK_EN
            lock_cnt_q <= 4'd0;
`endif
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            port_q     <= port_d;
            cnt_q      <= cnt_d;
            illegal_q  <= illegal_d;
            data1_q    <= data1_d;
            data2_q    <= data2_d;
            select_q   <= select_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            err_q      <= err_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            busy_q     <= busy_d;
`ifdef ALU_ARB_LOCK_EN
            lock_cnt_q <= lock_cnt_d;
`endif
        end
    end

    assign GNT0       = gnt0_q;
    assign GNT1       = gnt1_q;
    assign DONE0      = done0_q;
    assign DONE1      = done1_q;
    assign RESULT_OUT = result_q;
    assign ZERO_OUT   = zero_q;
    assign ERR_OUT    = err_q;
    assign ALU_DATA1  = data1_q;
    assign ALU_DATA2  = data2_q;
    assign ALU_SELECT = select_q;
    assign BUSY       = busy_q;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single 8-bit ALU between two requesters: port 0 is the CPU datapath control and port 1 is an auxiliary unit such as a multiply/branch helper. It arbitrates round-robin, registers operands and SELECT onto the ALU inputs, and waits a fixed number of cycles for the ALU to settle. It then captures RESULT and COMP and returns them to the winning port with a one-cycle DONE pulse. Only one operation is in flight at a time.

Parameters:
WAIT_CYCLES, 1, full clock cycles between driving ALU inputs and sampling ALU outputs; legal range 1..7.
LOCK_MAX, 4, maximum consecutive locked grants to one port; used only when ALU_ARB_LOCK_EN is defined.

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  asynchronous, active-high reset
VALID0 / VALID1  in  1  request pending on port 0 / port 1
OP0 / OP1  in  4  ALU SELECT code requested
A0 / A1  in  8  operand, driven to ALU DATA1
B0 / B1  in  8  operand, driven to ALU DATA2
GNT0 / GNT1  out  1  one-cycle pulse; operands captured at the edge ending this cycle
DONE0 / DONE1  out  1  one-cycle pulse; RESULT_OUT, ZERO_OUT and ERR_OUT are valid this cycle
RESULT_OUT  out  8  captured ALU result, held until the next capture
ZERO_OUT  out  1  captured ALU COMP
ERR_OUT  out  1  captured opcode-illegal flag
ALU_DATA1 / ALU_DATA2  out  8  registered ALU operands
ALU_SELECT  out  4  registered ALU opcode
ALU_RESULT  in  8  ALU RESULT
ALU_COMP  in  1  ALU COMP
BUSY  out  1  high in every state except IDLE

Behaviour:
- Reset is asynchronous: every output goes to 0, state goes to IDLE, LAST_GNT goes to 1, and any in-flight operation is discarded with no DONE pulse.
- States are IDLE, ISSUE, WAIT, RESP.
- IDLE: if any VALID is high, pick a winner. If only one port is valid, that port wins. If both are valid, the port not equal to LAST_GNT wins.
  - At the edge, go to ISSUE.
  - Latch the winner's A, B and OP into ALU_DATA1, ALU_DATA2 and ALU_SELECT.
  - Update LAST_GNT to the winner.
  - Load the wait counter with WAIT_CYCLES.
- ISSUE: GNTn is high for exactly this cycle. Next state is WAIT.
- WAIT: the counter decrements each cycle.
  - On the cycle the counter equals 1, the next edge captures ALU_RESULT into RESULT_OUT and ALU_COMP into ZERO_OUT, then moves to RESP.
  - ALU_* outputs stay stable throughout WAIT.
- RESP: DONEn is high for exactly this cycle. Next state is IDLE.
- Latency: a request seen in IDLE cycle K gives GNT in K+1 and DONE in K+2+WAIT_CYCLES. The minimum issue interval is WAIT_CYCLES+3 cycles.
- Illegal opcode (OP[3]=1):
  - The request is granted normally, but ALU_SELECT is forced to 4'b0000.
  - At capture, RESULT_OUT is forced to 0, ZERO_OUT to 1 and ERR_OUT to 1.
  - For legal opcodes, ERR_OUT is 0 at capture.
- VALIDn is sampled only in IDLE. Deasserting VALID before GNT withdraws the request silently. A requester re-asserting VALID after DONE is arbitrated fresh.
- Changes on A/B/OP after GNT have no effect on the in-flight operation.
- GNT0 and GNT1 are never high together. DONE0 and DONE1 are never high together. DONE always goes to the port that received the matching GNT.

Optional Feature:
ALU_ARB_LOCK_EN
- Defined:
  - Adds inputs LOCK0 and LOCK1.
  - If the granted port holds LOCKn high and VALIDn high in its RESP cycle, RESP goes directly to ISSUE for the same port, skipping IDLE and ignoring round-robin. This is a back-to-back issue with interval WAIT_CYCLES+2.
  - A lock counter limits this to LOCK_MAX consecutive grants. After that the port must pass through IDLE arbitration.
  - The lock counter clears on RESET and on any IDLE visit.
- Undefined: no LOCK ports exist and every operation returns through IDLE.

Test Plan:
- After reset, VALID0=1, OP0=0001, A0=8'h05, B0=8'h03 with WAIT_CYCLES=1: GNT0 at K+1, DONE0 at K+3, RESULT_OUT=8'h08, ZERO_OUT=0, ERR_OUT=0.
- VALID0 and VALID1 both held high with OP=0010 and differing operands: grants go 0,1,0,1 (first winner is port 0 since LAST_GNT resets to 1); each DONE matches its port's AND result, e.g. 8'hF0&8'h0F gives 8'h00 and ZERO_OUT=1.
- OP1=1010 with A1=8'hFF: ALU_SELECT is driven 0000; DONE1 returns RESULT_OUT=0, ZERO_OUT=1, ERR_OUT=1.
- RESET asserted mid-WAIT of a port-0 operation: outputs drop to 0 immediately, no DONE0 follows, and the next request is granted normally.
- VALID1 pulsed for one IDLE cycle while in WAIT for port 0: no GNT1 is issued and port 0 completes unaffected.
- With ALU_ARB_LOCK_EN, LOCK0=1, VALID0=1 and VALID1=1: port 0 receives exactly 4 back-to-back grants 3 cycles apart, then port 1 is granted.
